// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
//   wb_state_e : writeback FSM states
//   DST_*      : encodings of the in_reg_dst destination selector
//   RA_ADDR    : link register ($ra) used by jal
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_LOAD = 2'd2,
    DRAIN     = 2'd3
  } wb_state_e;

  localparam logic [1:0] DST_RA   = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_RD   = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  localparam logic [4:0] RA_ADDR = 5'd31;

endpackage

// File: rtl/wb_writer_if.sv
// MEM -> WB instruction handshake bundle.
//   master : MEM stage (drives in_valid and the instruction fields)
//   slave  : wb_writer (drives in_ready)
// Handshake: an instruction transfers on a rising clock edge where
// in_valid and in_ready are both 1. in_valid does not depend on in_ready;
// in_ready depends only on the writeback state, never on in_valid. The
// writeback stage additionally refuses the transfer while its flush input
// is high.
interface wb_writer_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic          in_reg_write;
  logic [1:0]    in_reg_dst;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic          in_mem_to_reg;
  logic          in_wr_reg_data;
  logic [DW-1:0] in_alu_result;
  logic [DW-1:0] in_pc_word;

  modport master (
    output in_valid, in_reg_write, in_reg_dst, in_rt, in_rd,
           in_mem_to_reg, in_wr_reg_data, in_alu_result, in_pc_word,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_reg_dst, in_rt, in_rd,
           in_mem_to_reg, in_wr_reg_data, in_alu_result, in_pc_word,
    output in_ready
  );
endinterface

// File: rtl/wb_dst_sel.sv
// Combinational destination / data select for the writeback stage.
// Ports:
//   reg_write_i, reg_dst_i, rt_i, rd_i : destination controls
//   wr_reg_data_i                      : 1 = ALU result, 0 = jal link value
//   alu_result_i, pc_word_i            : data sources
//   we_o                               : write qualifies (reg_write and dst != $0)
//   waddr_o, wdata_o                   : address/data, forced to 0 when we_o = 0
// Load data is not selected here; the FSM substitutes mem_rdata when it arrives.
module wb_dst_sel
  import wb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int LINK_OFFSET = 3
) (
  input  logic          reg_write_i,
  input  logic [1:0]    reg_dst_i,
  input  logic [4:0]    rt_i,
  input  logic [4:0]    rd_i,
  input  logic          wr_reg_data_i,
  input  logic [DW-1:0] alu_result_i,
  input  logic [DW-1:0] pc_word_i,
  output logic          we_o,
  output logic [4:0]    waddr_o,
  output logic [DW-1:0] wdata_o
);

  logic [4:0]    dst;
  logic [DW-1:0] link;
  logic [DW-1:0] src;

  always_comb begin
    dst = '0;
    case (reg_dst_i)
      DST_RA:  dst = RA_ADDR;
      DST_RT:  dst = rt_i;
      DST_RD:  dst = rd_i;
      default: dst = '0;
    endcase
  end

  // pc_word is a word index; convert back to a byte address after correcting.
  assign link = (pc_word_i - DW'(LINK_OFFSET)) << 2;
  assign src  = wr_reg_data_i ? alu_result_i : link;

  assign we_o    = reg_write_i && (dst != '0);
  assign waddr_o = we_o ? dst : '0;
  assign wdata_o = we_o ? src : '0;

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: producer side of the register-file write port.
// Build option: define WB_FWD_EN to drive fwd_* / load_pending; otherwise
// those outputs are tied to 0.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_if (slave)       : MEM/WB instruction handshake
//   flush               : squash an in-flight load and any same-cycle accept
//   mem_rvalid/rdata    : returned load data (one-cycle pulse)
//   rf_we/waddr/wdata   : registered single-cycle register-file write
//   err_rvalid          : sticky, mem_rvalid seen when no load was waiting
//   fwd_*, load_pending : forwarding / hazard information
//   dbg_state_o         : current FSM state
module wb_writer
  import wb_pkg::*;
#(
  parameter int LINK_OFFSET = 3,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_writer_if.slave    in_if,
  input  logic          flush,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          err_rvalid,
  output logic          fwd_valid,
  output logic [4:0]    fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic          load_pending,
  output wb_state_e     dbg_state_o
);

  wb_state_e     state_q;
  logic          we_q;
  logic [4:0]    waddr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic          pend_we_q;
  logic [4:0]    pend_addr_q;

  logic          sel_we;
  logic [4:0]    sel_addr;
  logic [DW-1:0] sel_data;
  logic          accept;

  wb_dst_sel #(.DW(DW), .LINK_OFFSET(LINK_OFFSET)) u_dst_sel (
    .reg_write_i   (in_if.in_reg_write),
    .reg_dst_i     (in_if.in_reg_dst),
    .rt_i          (in_if.in_rt),
    .rd_i          (in_if.in_rd),
    .wr_reg_data_i (in_if.in_wr_reg_data),
    .alu_result_i  (in_if.in_alu_result),
    .pc_word_i     (in_if.in_pc_word),
    .we_o          (sel_we),
    .waddr_o       (sel_addr),
    .wdata_o       (sel_data)
  );

  assign in_if.in_ready = (state_q == IDLE) || (state_q == WRITE);
  assign accept         = in_if.in_valid && in_if.in_ready && !flush;

  // The write port defaults to idle every cycle so each write is one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      case (state_q)
        IDLE, WRITE: begin
          // No load is outstanding here, so any returned data is unexpected.
          if (mem_rvalid) err_q <= 1'b1;
          if (accept) begin
            if (in_if.in_mem_to_reg) begin
              state_q     <= WAIT_LOAD;
              pend_we_q   <= sel_we;
              pend_addr_q <= sel_addr;
            end else begin
              state_q <= WRITE;
              we_q    <= sel_we;
              waddr_q <= sel_addr;
              wdata_q <= sel_data;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            if (flush) begin
              state_q <= IDLE;
            end else begin
              state_q <= WRITE;
              we_q    <= pend_we_q;
              waddr_q <= pend_addr_q;
              wdata_q <= pend_we_q ? mem_rdata : '0;
            end
          end else if (flush) begin
            // The load is squashed but memory will still answer; swallow it.
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign err_rvalid  = err_q;
  assign dbg_state_o = state_q;

`ifdef WB_FWD_EN
  assign load_pending = (state_q == WAIT_LOAD) && pend_we_q;
  assign fwd_valid    = we_q;
  assign fwd_addr     = load_pending ? pend_addr_q : waddr_q;
  assign fwd_data     = wdata_q;
`else
  assign load_pending = 1'b0;
  assign fwd_valid    = 1'b0;
  assign fwd_addr     = '0;
  assign fwd_data     = '0;
`endif

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
Writeback stage for the 5-stage pipelined CPU. It is the producer side of the register-file write port. It holds the MEM/WB pipeline slot and selects the destination register (rt, rd or $ra). It selects write data from the ALU result, returned load data, or the jal link address. Every register-file write is a registered, single-cycle pulse. Loads with variable memory latency stall upstream until the data returns.

Parameters:
LINK_OFFSET, 3, word-index correction applied to pc_word when forming the jal link value.
DW, 32, datapath width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  MEM stage presents an instruction.
in_ready  out  1  wb_writer can accept the instruction this cycle.
in_reg_write  in  1  instruction writes a register.
in_reg_dst  in  2  00=$31, 01=rt, 10=rd, 11=$0 (no write).
in_rt, in_rd  in  5 each  candidate destinations.
in_mem_to_reg  in  1  1=load; data comes from mem_rdata.
in_wr_reg_data  in  1  0=link value, 1=ALU or load data.
in_alu_result  in  DW  R-type/immediate result.
in_pc_word  in  DW  word-index PC used for the link value.
flush  in  1  squash the in-flight load and any same-cycle accept.
mem_rvalid  in  1  load data valid (one-cycle pulse).
mem_rdata  in  DW  load data.
rf_we  out  1  register-file write enable.
rf_waddr  out  5  write address.
rf_wdata  out  DW  write data.
err_rvalid  out  1  sticky flag for an unexpected mem_rvalid.
fwd_valid  out  1  forwarding/hazard information (see Optional Feature).
fwd_addr  out  5  forwarding/hazard information (see Optional Feature).
fwd_data  out  DW  forwarding/hazard information (see Optional Feature).
load_pending  out  1  forwarding/hazard information (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0 except in_ready, which is 1.
- Destination: dst = {31, rt, rd, 0}[in_reg_dst].
- Write qualification: a write occurs only if in_reg_write=1 and dst!=0. Otherwise the slot is consumed with rf_we held 0.
- Link value: (in_pc_word - LINK_OFFSET) << 2, truncated to DW, modulo 2^DW.
- Accept: an instruction is accepted when in_valid & in_ready & ~flush.
- States:
  - IDLE: on a non-load accept -> WRITE. On a load accept -> WAIT_LOAD.
  - WRITE: rf_we is driven from registered values. It can accept a new instruction in the same cycle (back-to-back, no bubble). Accept transitions are the same as in IDLE; with no accept -> IDLE.
  - WAIT_LOAD: in_ready=0. On mem_rvalid, capture mem_rdata -> WRITE. On flush without mem_rvalid -> DRAIN. If flush and mem_rvalid occur together, the data is discarded -> IDLE.
  - DRAIN: in_ready=0. On mem_rvalid, discard -> IDLE.
- Latency:
  - Non-load accepted at edge N: rf_we=1 during cycle N+1, for exactly one cycle.
  - Load: rf_we=1 during the cycle after the edge that samples mem_rvalid.
- Minimum load latency is 1 cycle. mem_rvalid in IDLE or WRITE, including the accept cycle, sets err_rvalid and is otherwise ignored. err_rvalid clears only on reset.
- flush never cancels a write already in WRITE state; that write is committed.
- When a write is suppressed, rf_waddr and rf_wdata are held at 0.

Optional Feature:
WB_FWD_EN
- Defined:
  - fwd_valid, fwd_addr and fwd_data mirror rf_we, rf_waddr and rf_wdata combinationally.
  - load_pending=1 in WAIT_LOAD when the load will write.
  - While load_pending=1, fwd_addr carries the pending load destination.
- Undefined: all fwd_* outputs and load_pending are tied to 0, and no extra logic is generated.

Decomposition:
- Shared package wb_pkg:
  - state enum (IDLE, WRITE, WAIT_LOAD, DRAIN);
  - RegDst encodings (DST_RA, DST_RT, DST_RD, DST_NONE);
  - RA_ADDR=5'd31.
- One natural sub-module, wb_dst_sel: combinational dst/link/data select and write qualification. The FSM and output registers stay in wb_writer.

Test Plan:
1. Reset test: assert rst_n=0 mid-WAIT_LOAD -> immediately rf_we=0, err_rvalid=0, in_ready=1. After release, a following ALU op writes normally.
2. ALU op: reg_dst=10, rd=5, alu=0x00001234, reg_write=1, wr_reg_data=1 -> next cycle rf_we=1, waddr=5, wdata=0x00001234, for one cycle.
3. jal: reg_dst=00, wr_reg_data=0, pc_word=0x10 -> rf_waddr=31, rf_wdata=0x34. Repeat with pc_word=0x1 -> wdata=0xFFFFFFF8.
4. Load: rt=8, reg_dst=01; mem_rvalid 3 cycles after accept with rdata=0xDEADBEEF -> in_ready=0 for 3 cycles. The next cycle has rf_we=1, waddr=8, wdata=0xDEADBEEF. A back-to-back ALU op immediately after is accepted with no bubble.
5. Dest $0: reg_dst=01, rt=0, reg_write=1 -> rf_we stays 0 and the slot is consumed.
6. Flush and spurious rvalid:
   - Flush in WAIT_LOAD, then mem_rvalid 2 cycles later -> no write, err_rvalid=0, in_ready=1 after the drain.
   - A later mem_rvalid in IDLE -> err_rvalid=1, held until reset.
